noc_inject_sched: RTL and testbench
===================================

Name: noc_inject_sched

Overview:
- Clocked scheduler that shares the single NoC injection port among three packet sources: filter loader (req 0), ifmap loader (req 1) and spike writeback (req 2).
- Enforces the layer phase: all filter packets go out before any ifmap or spike traffic.
- Gates each packet on a per-destination credit count.
- Sits between the loaders and the local router input.

Parameters:
- WIDTH, 35, packet width; [34:31] src, [30:27] dst, [26:24] type, [23:0] payload
- NREQ, 3, number of requesters (fixed index roles above)
- NNODE, 16, mesh nodes (4x4); one credit counter per node
- CREDITS, 2, initial and maximum credits per destination
- FILTER_PKTS, 10, filter packets per layer (one per PE)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins (or restarts) a layer
- req_valid  in  NREQ  per-requester packet valid
- req_data  in  NREQ*WIDTH  packets, requester i at [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot accept; at most one bit high per cycle
- out_valid  out  1  injection packet valid
- out_data  out  WIDTH  injection packet
- out_ready  in  1  router accepts out_data
- credit_ret_valid  in  1  one credit returned this cycle
- credit_ret_node  in  4  node whose credit is returned
- phase  out  2  0=IDLE, 1=FILTER, 2=RUN
- filter_done  out  1  one-cycle pulse when the last filter packet is accepted
- credit_err  out  1  sticky; set on a credit return to a node already at CREDITS

Behaviour:
- Reset:
  - phase=IDLE; out_valid=0; out_data=0; req_ready=0; filter_done=0; credit_err=0.
  - All credit counters = CREDITS; filter counter = 0; round-robin pointer = 0.
- Handshake: a transfer happens on valid&ready in the same cycle. Requesters hold valid/data stable until ready.
- FSM:
  - IDLE: start -> FILTER.
  - FILTER: only req 0 is eligible. Filter counter increments on each accept. The accept that makes the count FILTER_PKTS pulses filter_done and moves to RUN next cycle.
  - RUN: reqs 1 and 2 are eligible; req 0 is blocked.
  - start in FILTER or RUN -> FILTER with filter counter cleared. An in-flight output register is not flushed. Credits are not reset.
- Eligibility: req i is eligible when req_valid[i] is high, its phase mask allows it, and credit[dst of req_data[i]] > 0.
- Arbitration: round-robin over eligible requesters, starting at the pointer. After a grant to i, pointer = (i+1) mod NREQ. No grant leaves the pointer unchanged.
- Grant condition: at most one grant per cycle, and only when the output register is empty or being drained (out_valid & out_ready).
- Latency: grant in cycle N -> out_valid/out_data in cycle N+1. Full throughput of one packet/cycle while out_ready=1.
- Credits:
  - An accept decrements credit[dst].
  - credit_ret_valid increments credit[credit_ret_node].
  - Decrement and return on the same node in the same cycle: net unchanged.
  - Return to a node at CREDITS: counter unchanged, credit_err set.
  - A counter never goes below 0, because a zero-credit destination is never eligible.
- Backpressure: out_valid=1 & out_ready=0 holds out_data stable, and req_ready=0.
- Reset mid-operation: all state returns to reset values next edge; the packet in the output register is dropped.

Optional Feature:
- Macro INJ_STATS_EN.
- When defined, add outputs:
  - pkt_cnt (NREQ x 16 bits): saturating count of accepted packets per requester.
  - stall_cnt (16 bits): saturating count of cycles with out_valid=1 & out_ready=0.
  - Both counters clear on rst and on start.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package noc_pkg holds:
  - the packet field-slice constants (SRC/DST/TYPE/PAYLOAD msb/lsb);
  - the phase enum (IDLE, FILTER, RUN);
  - NNODE and WIDTH;
  - the PE node addresses.
- Sub-module rr_arbiter (NREQ-wide: eligible mask in, one-hot grant out, pointer update on grant_en). Reusable by other schedulers.

Test Plan:
1. Reset, start, req0 presents 10 packets to dst 0x8..0xE with out_ready=1, credit returns looped back -> 10 outputs in order; filter_done pulses on the 10th accept; phase=2 next cycle.
2. In FILTER, req1 and req2 valid continuously -> req_ready[1]=req_ready[2]=0 until phase=RUN.
3. RUN, req1 and req2 always valid to distinct nodes with ample credit -> grants alternate 1,2,1,2; out_valid stays high.
4. dst 0x5 credits exhausted (2 accepts, no return) -> 3rd packet to 0x5 stalls. A credit_ret on node 0x5 in cycle N -> accept in cycle N+1.
5. out_ready=0 for 5 cycles with out_valid=1 -> out_data stable, no req_ready. out_ready=1 -> drain and a new grant in the same cycle.
6. credit_ret to a node at CREDITS -> credit_err=1 and sticky. rst asserted mid-RUN -> phase=0, out_valid=0, credits=2.

Source files
------------

// File: rtl/noc_inject_sched_pkg.sv
// Shared NoC definitions: packet field slices, layer phase encoding,
// mesh size and PE node map. Imported by the injection scheduler slice.
package noc_pkg;

    localparam int unsigned WIDTH       = 35;
    localparam int unsigned NREQ        = 3;
    localparam int unsigned NNODE       = 16;
    localparam int unsigned NODE_W      = 4;
    localparam int unsigned CREDITS     = 2;
    localparam int unsigned FILTER_PKTS = 10;

    // Packet layout: [34:31] src, [30:27] dst, [26:24] type, [23:0] payload
    localparam int unsigned SRC_MSB     = 34;
    localparam int unsigned SRC_LSB     = 31;
    localparam int unsigned DST_MSB     = 30;
    localparam int unsigned DST_LSB     = 27;
    localparam int unsigned TYPE_MSB    = 26;
    localparam int unsigned TYPE_LSB    = 24;
    localparam int unsigned PAYLOAD_MSB = 23;
    localparam int unsigned PAYLOAD_LSB = 0;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_FILTER = 2'd1,
        PH_RUN    = 2'd2
    } phase_t;

    // Mesh node address of each PE (one filter packet per PE per layer)
    localparam logic [NODE_W-1:0] PE_NODE [FILTER_PKTS] = '{
        4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE
    };

    function automatic logic [NODE_W-1:0] pkt_dst(input logic [WIDTH-1:0] pkt);
        return pkt[DST_MSB:DST_LSB];
    endfunction

endpackage

// File: rtl/noc_inject_sched_if.sv
// Injection scheduler bus: requester packets in, one injection stream out,
// plus the credit return path from the router.
interface noc_inject_sched_if;
    import noc_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_ready;
    logic                  credit_ret_valid;
    logic [NODE_W-1:0]     credit_ret_node;

    // Loaders / router side
    modport master (
        output req_valid, req_data, out_ready, credit_ret_valid, credit_ret_node,
        input  req_ready, out_valid, out_data
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_data, out_ready, credit_ret_valid, credit_ret_node,
        output req_ready, out_valid, out_data
    );

endinterface

// File: rtl/noc_inject_sched_rr_arbiter.sv
// Generic N-way round-robin arbiter: one-hot grant of the first eligible
// requester at or after the pointer; pointer moves past the winner only
// when the grant is actually taken (grant_en).
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] eligible,
    input  logic         grant_en,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;

    // Search eligible requesters starting at the pointer
    always_comb begin
        int unsigned idx;
        idx   = 0;
        grant = '0;
        win   = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = PW'(idx);
            end
        end
    end

    // Advance pointer past the winner of a taken grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_en && found) begin
            ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
        end
    end

endmodule

// File: rtl/noc_inject_sched.sv
// NoC injection scheduler: shares the local router input among the filter
// loader (req 0), ifmap loader (req 1) and spike writeback (req 2), enforcing
// filter-before-run layer phasing and per-destination credit flow control.
// Optional build macro: INJ_STATS_EN adds pkt_cnt / stall_cnt counters.
module noc_inject_sched
    import noc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    noc_inject_sched_if.slave   bus,
    output logic [1:0]          phase,
    output logic                filter_done,
    output logic                credit_err
`ifdef INJ_STATS_EN
    ,
    output logic [NREQ*16-1:0]  pkt_cnt,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int unsigned CW  = $clog2(CREDITS + 1);
    localparam int unsigned FCW = $clog2(FILTER_PKTS + 1);

    phase_t              phase_q;
    logic [FCW-1:0]      filt_cnt;
    logic [CW-1:0]       credit [NNODE];
    logic                out_valid_q;
    logic [WIDTH-1:0]    out_data_q;

    logic [WIDTH-1:0]    pkt [NREQ];
    logic [NREQ-1:0]     mask;
    logic [NREQ-1:0]     eligible;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     req_ready;
    logic                grant_en;
    logic                accept;
    logic [WIDTH-1:0]    win_pkt;
    logic [NNODE-1:0]    dec_vec;
    logic [NNODE-1:0]    inc_vec;

    // Phase mask: filter traffic only in FILTER, ifmap/spike only in RUN
    always_comb begin
        mask = '0;
        case (phase_q)
            PH_FILTER: mask = 3'b001;
            PH_RUN:    mask = 3'b110;
            default:   mask = '0;
        endcase
    end

    // Eligibility: valid, allowed by phase, destination has a credit
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pkt[i]      = bus.req_data[i*WIDTH +: WIDTH];
            eligible[i] = bus.req_valid[i] && mask[i] && (credit[pkt_dst(pkt[i])] != '0);
        end
    end

    // A grant is only taken when the output register is free or draining
    assign grant_en  = !rst && (!out_valid_q || bus.out_ready);
    assign req_ready = grant & {NREQ{grant_en}};
    assign accept    = |req_ready;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible),
        .grant_en (grant_en),
        .grant    (grant)
    );

    // Select the accepted packet and derive per-node credit events
    always_comb begin
        win_pkt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            win_pkt = win_pkt | (pkt[i] & {WIDTH{req_ready[i]}});
        end
        dec_vec = '0;
        inc_vec = '0;
        for (int unsigned n = 0; n < NNODE; n++) begin
            dec_vec[n] = accept && (pkt_dst(win_pkt) == NODE_W'(n));
            inc_vec[n] = bus.credit_ret_valid && (bus.credit_ret_node == NODE_W'(n));
        end
    end

    // Layer phase FSM and filter packet counter
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_IDLE;
            filt_cnt <= '0;
        end else if (start) begin
            phase_q  <= PH_FILTER;
            filt_cnt <= '0;
        end else if (phase_q == PH_FILTER && req_ready[0]) begin
            filt_cnt <= filt_cnt + FCW'(1);
            if (filt_cnt == FCW'(FILTER_PKTS - 1)) begin
                phase_q <= PH_RUN;
            end
        end
    end

    assign filter_done = (phase_q == PH_FILTER) && req_ready[0] &&
                         (filt_cnt == FCW'(FILTER_PKTS - 1));
    assign phase       = phase_q;

    // Output register: load on accept, empty once drained
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= win_pkt;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.req_ready = req_ready;

    // Per-destination credit counters and sticky over-return flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned n = 0; n < NNODE; n++) begin
                credit[n] <= CW'(CREDITS);
            end
            credit_err <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < NNODE; n++) begin
                if (dec_vec[n] && !inc_vec[n]) begin
                    credit[n] <= credit[n] - CW'(1);
                end else if (inc_vec[n] && !dec_vec[n]) begin
                    if (credit[n] == CW'(CREDITS)) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit[n] <= credit[n] + CW'(1);
                    end
                end
            end
        end
    end

`ifdef INJ_STATS_EN
    logic [15:0] pkt_q [NREQ];
    logic [15:0] stall_q;

    // Saturating accept and backpressure-cycle counters
    always_ff @(posedge clk) begin
        if (rst || start) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                pkt_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req_ready[i] && pkt_q[i] != '1) begin
                    pkt_q[i] <= pkt_q[i] + 16'd1;
                end
            end
            if (out_valid_q && !bus.out_ready && stall_q != '1) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    // Flatten per-requester counts onto the output bus
    always_comb begin
        pkt_cnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pkt_cnt[i*16 +: 16] = pkt_q[i];
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_noc_inject_sched.sv
// Directed bench for noc_inject_sched: table of per-cycle vectors for the
// filter/run phases, then hand sequences for credit stall, backpressure,
// credit error and mid-run reset.
module tb_noc_inject_sched;
    import noc_pkg::*;

    logic clk;
    logic rst;
    logic start;
    logic [1:0] phase;
    logic filter_done;
    logic credit_err;
`ifdef INJ_STATS_EN
    logic [NREQ*16-1:0] pkt_cnt;
    logic [15:0] stall_cnt;
`endif

    noc_inject_sched_if bus ();

    noc_inject_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .phase       (phase),
        .filter_done (filter_done),
        .credit_err  (credit_err)
`ifdef INJ_STATS_EN
        ,
        .pkt_cnt     (pkt_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        start;
        logic [2:0]  rv;
        logic [34:0] d0, d1, d2;
        logic        crv;
        logic [3:0]  crn;
        logic [2:0]  e_rr;
        logic        e_fd;
        logic        e_ov;
        logic [34:0] e_od;
        logic [1:0]  e_ph;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [34:0] mk(input logic [3:0] s, input logic [3:0] d,
                                       input logic [2:0] t, input logic [23:0] p);
        return {s, d, t, p};
    endfunction

    function automatic logic [34:0] pf(input int k);
        logic [3:0] d;
        d = 4'(8 + (k % 7));
        return mk(4'h0, d, 3'd1, 24'h000100 + 24'(k));
    endfunction

    function automatic logic [34:0] r1(input int j);
        return mk(4'h1, 4'h1, 3'd2, 24'h001000 + 24'(j));
    endfunction

    function automatic logic [34:0] r2(input int j);
        return mk(4'h2, 4'h2, 3'd3, 24'h002000 + 24'(j));
    endfunction

    function automatic vec_t mkv(input logic st, input logic [2:0] rv,
                                 input logic [34:0] d0, input logic [34:0] d1, input logic [34:0] d2,
                                 input logic crv, input logic [3:0] crn,
                                 input logic [2:0] e_rr, input logic e_fd, input logic e_ov,
                                 input logic [34:0] e_od, input logic [1:0] e_ph);
        vec_t v;
        v.start = st; v.rv = rv; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.crv = crv; v.crn = crn; v.e_rr = e_rr; v.e_fd = e_fd;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ph = e_ph;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] rv, input logic [34:0] d0, input logic [34:0] d1,
                         input logic [34:0] d2, input logic ordy, input logic crv,
                         input logic [3:0] crn);
        bus.req_valid        = rv;
        bus.req_data         = {d2, d1, d0};
        bus.out_ready        = ordy;
        bus.credit_ret_valid = crv;
        bus.credit_ret_node  = crn;
    endtask

    logic [34:0] pa, pb, pc, pd, pe, pz;

    initial begin
        // Filter phase: req1/req2 held valid but blocked; credit returns loop back
        tbl[0]  = mkv(1, 3'b111, pf(0),  r1(0), r2(0), 0, 4'h0, 3'b000, 0, 0, '0,    2'd0);
        tbl[1]  = mkv(0, 3'b111, pf(0),  r1(0), r2(0), 0, 4'h0, 3'b001, 0, 0, '0,    2'd1);
        tbl[2]  = mkv(0, 3'b111, pf(1),  r1(0), r2(0), 1, 4'h8, 3'b001, 0, 1, pf(0), 2'd1);
        tbl[3]  = mkv(0, 3'b111, pf(2),  r1(0), r2(0), 1, 4'h9, 3'b001, 0, 1, pf(1), 2'd1);
        tbl[4]  = mkv(0, 3'b111, pf(3),  r1(0), r2(0), 1, 4'hA, 3'b001, 0, 1, pf(2), 2'd1);
        tbl[5]  = mkv(0, 3'b111, pf(4),  r1(0), r2(0), 1, 4'hB, 3'b001, 0, 1, pf(3), 2'd1);
        tbl[6]  = mkv(0, 3'b111, pf(5),  r1(0), r2(0), 1, 4'hC, 3'b001, 0, 1, pf(4), 2'd1);
        tbl[7]  = mkv(0, 3'b111, pf(6),  r1(0), r2(0), 1, 4'hD, 3'b001, 0, 1, pf(5), 2'd1);
        tbl[8]  = mkv(0, 3'b111, pf(7),  r1(0), r2(0), 1, 4'hE, 3'b001, 0, 1, pf(6), 2'd1);
        tbl[9]  = mkv(0, 3'b111, pf(8),  r1(0), r2(0), 1, 4'h8, 3'b001, 0, 1, pf(7), 2'd1);
        tbl[10] = mkv(0, 3'b111, pf(9),  r1(0), r2(0), 1, 4'h9, 3'b001, 1, 1, pf(8), 2'd1);
        // Run phase: req0 blocked, req1/req2 alternate
        tbl[11] = mkv(0, 3'b111, pf(10), r1(0), r2(0), 1, 4'hA, 3'b010, 0, 1, pf(9), 2'd2);
        tbl[12] = mkv(0, 3'b111, pf(10), r1(1), r2(0), 1, 4'h1, 3'b100, 0, 1, r1(0), 2'd2);
        tbl[13] = mkv(0, 3'b111, pf(10), r1(1), r2(1), 1, 4'h2, 3'b010, 0, 1, r2(0), 2'd2);
        tbl[14] = mkv(0, 3'b111, pf(10), r1(2), r2(1), 1, 4'h1, 3'b100, 0, 1, r1(1), 2'd2);
        tbl[15] = mkv(0, 3'b111, pf(10), r1(2), r2(2), 1, 4'h2, 3'b010, 0, 1, r2(1), 2'd2);

        pz = '0;
        rst = 1'b1;
        start = 1'b0;
        drive(3'b000, pz, pz, pz, 1'b1, 1'b0, 4'h0);
        step();
        step();
        #1;
        chk("rst_phase", 64'(phase), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_filter_done", 64'(filter_done), 64'd0);
        chk("rst_credit_err", 64'(credit_err), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            start = tbl[i].start;
            drive(tbl[i].rv, tbl[i].d0, tbl[i].d1, tbl[i].d2, 1'b1, tbl[i].crv, tbl[i].crn);
            #1;
            chk($sformatf("v%0d_req_ready", i), 64'(bus.req_ready), 64'(tbl[i].e_rr));
            chk($sformatf("v%0d_filter_done", i), 64'(filter_done), 64'(tbl[i].e_fd));
            chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov)
                chk($sformatf("v%0d_out_data", i), 64'(bus.out_data), 64'(tbl[i].e_od));
            chk($sformatf("v%0d_phase", i), 64'(phase), 64'(tbl[i].e_ph));
            chk($sformatf("v%0d_credit_err", i), 64'(credit_err), 64'd0);
            step();
        end

        // Settle: return credit for r1(2), idle requesters
        start = 1'b0;
        drive(3'b000, pz, pz, pz, 1'b1, 1'b1, 4'h1);
        #1;
        chk("settle_out_data", 64'(bus.out_data), 64'(r1(2)));
        step();

        // Credit exhaustion on node 5 via req1
        pa = mk(4'h1, 4'h5, 3'd2, 24'h00A001);
        pb = mk(4'h1, 4'h5, 3'd2, 24'h00A002);
        pc = mk(4'h1, 4'h5, 3'd2, 24'h00A003);
        drive(3'b010, pz, pa, pz, 1'b1, 1'b0, 4'h0);
        #1; chk("cr_acc1", 64'(bus.req_ready), 64'b010);
        step();
        drive(3'b010, pz, pb, pz, 1'b1, 1'b0, 4'h0);
        #1; chk("cr_acc2", 64'(bus.req_ready), 64'b010);
        step();
        drive(3'b010, pz, pc, pz, 1'b1, 1'b0, 4'h0);
        #1; chk("cr_stall1", 64'(bus.req_ready), 64'b000);
        chk("cr_out_b", 64'(bus.out_data), 64'(pb));
        step();
        #1; chk("cr_stall2", 64'(bus.req_ready), 64'b000);
        chk("cr_out_drained", 64'(bus.out_valid), 64'd0);
        step();
        drive(3'b010, pz, pc, pz, 1'b1, 1'b1, 4'h5);
        #1; chk("cr_ret_cycle", 64'(bus.req_ready), 64'b000);
        step();
        drive(3'b010, pz, pc, pz, 1'b1, 1'b0, 4'h0);
        #1; chk("cr_accept_after_ret", 64'(bus.req_ready), 64'b010);
        step();

        // Backpressure: 5 stalled cycles, then drain with a grant in the same cycle
        pd = mk(4'h2, 4'h3, 3'd3, 24'h00B001);
        for (int s = 0; s < 5; s++) begin
            drive(3'b100, pz, pz, pd, 1'b0, (s < 2) ? 1'b1 : 1'b0, 4'h5);
            #1;
            chk($sformatf("bp%0d_out_valid", s), 64'(bus.out_valid), 64'd1);
            chk($sformatf("bp%0d_out_data", s), 64'(bus.out_data), 64'(pc));
            chk($sformatf("bp%0d_req_ready", s), 64'(bus.req_ready), 64'b000);
            step();
        end
        drive(3'b100, pz, pz, pd, 1'b1, 1'b0, 4'h0);
        #1;
        chk("bp_release_req_ready", 64'(bus.req_ready), 64'b100);
        chk("bp_release_out_data", 64'(bus.out_data), 64'(pc));
        step();

        // Over-return on node 4 sets a sticky error
        drive(3'b000, pz, pz, pz, 1'b1, 1'b1, 4'h4);
        #1;
        chk("bp_new_out_data", 64'(bus.out_data), 64'(pd));
        chk("err_before", 64'(credit_err), 64'd0);
        step();
        drive(3'b000, pz, pz, pz, 1'b1, 1'b0, 4'h0);
        #1;
        chk("err_set", 64'(credit_err), 64'd1);
        step();

        // Mid-run reset with a packet in flight
        pe = mk(4'h1, 4'h6, 3'd2, 24'h00C001);
        drive(3'b010, pz, pe, pz, 1'b1, 1'b0, 4'h0);
        #1;
        chk("err_sticky", 64'(credit_err), 64'd1);
        chk("pre_rst_grant", 64'(bus.req_ready), 64'b010);
        step();
        rst = 1'b1;
        drive(3'b010, pz, mk(4'h1, 4'h6, 3'd2, 24'h00C002), pz, 1'b1, 1'b0, 4'h0);
        #1;
        chk("in_rst_out_data", 64'(bus.out_data), 64'(pe));
        chk("in_rst_phase", 64'(phase), 64'd2);
        chk("in_rst_req_ready", 64'(bus.req_ready), 64'b000);
        step();
        rst = 1'b0;
        drive(3'b000, pz, pz, pz, 1'b1, 1'b1, 4'h3);
        #1;
        chk("post_rst_phase", 64'(phase), 64'd0);
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("post_rst_out_data", 64'(bus.out_data), 64'd0);
        chk("post_rst_credit_err", 64'(credit_err), 64'd0);
        step();
        // Node 3 had one credit outstanding before reset; restored to full, so the return overflows
        start = 1'b1;
        drive(3'b000, pz, pz, pz, 1'b1, 1'b0, 4'h0);
        #1;
        chk("post_rst_credit_full", 64'(credit_err), 64'd1);
        step();
        start = 1'b0;
        #1;
        chk("restart_phase", 64'(phase), 64'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
